// File: rtl/sense_seq_ctrl.sv
// sense_seq_ctrl: LED excite / settle / sample / clear sequencer for the
// comparator latch, with synchronized, debounced sampling and a hit counter.
module sense_seq_ctrl #(
  parameter int EXCITE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int DEBOUNCE      = 4,
  parameter int PERIOD_CYCLES = 256,
  parameter int CLR_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       run,
  input  logic       cmp_in,
  input  logic       cnt_clr,
  output logic       led_en,
  output logic       latch_clr,
  output logic       sample_valid,
  output logic       sample_bit,
  output logic [7:0] hit_count,
  output logic       busy
);

  localparam int TW = $clog2(PERIOD_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [TW-1:0] T_EXC_END =
    TW'(EXCITE_CYCLES - 1);
  localparam logic [TW-1:0] T_SET_END =
    TW'(EXCITE_CYCLES + SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_CLR_END =
    TW'(EXCITE_CYCLES + SETTLE_CYCLES + CLR_CYCLES);
  localparam logic [TW-1:0] T_PER_END =
    TW'(PERIOD_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXCITE,
    SETTLE,
    SAMPLE,
    CLEAR,
    WAIT
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   t_q;
  logic [TW-1:0]   t_d;
  logic [1:0]      sync_q;
  logic [DW-1:0]   deb_q;
  logic            filt_q;
  logic            samp_q;
  logic [7:0]      hit_q;

  // cmp_in is asynchronous to clk; two flops before anything looks at it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], cmp_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] != filt_q) begin
      if (deb_q == DEB_LAST) begin
        deb_q  <= '0;
        filt_q <= sync_q[1];
      end else begin
        deb_q <= deb_q + 1'b1;
      end
    end else begin
      deb_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run) state_d = EXCITE;
      EXCITE:  if (t_q == T_EXC_END) state_d = SETTLE;
      SETTLE:  if (t_q == T_SET_END) state_d = SAMPLE;
      SAMPLE:  state_d = CLEAR;
      CLEAR:   if (t_q == T_CLR_END) state_d = run ? WAIT : IDLE;
      WAIT:    if (t_q >= T_PER_END) state_d = run ? EXCITE : IDLE;
      default: state_d = IDLE;
    endcase
    if (!ena) state_d = IDLE;
  end

  // period timer reads 0 on the first EXCITE cycle of every period
  always_comb begin
    t_d = t_q + 1'b1;
    if (state_q == IDLE) t_d = '0;
    if (state_d == EXCITE && state_q != EXCITE) t_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= 1'b0;
      hit_q  <= 8'd0;
    end else begin
      if (state_q == SAMPLE) samp_q <= filt_q;
      if (cnt_clr) begin
        hit_q <= 8'd0;
      end else if (state_q == SAMPLE && filt_q && hit_q != 8'hff) begin
        hit_q <= hit_q + 8'd1;
      end
    end
  end

  // outputs decode straight from the state flops so rst drops them at once
  assign led_en       = (state_q == EXCITE) || (state_q == SETTLE);
  assign latch_clr    = (state_q == CLEAR);
  assign sample_valid = (state_q == SAMPLE);
  assign sample_bit   = (state_q == SAMPLE) ? filt_q : samp_q;
  assign hit_count    = hit_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sense_seq_ctrl.sv
// tb_sense_seq_ctrl: directed-vector bench for sense_seq_ctrl
// using default parameters (24-cycle excite+settle, 256-cycle period).
module tb_sense_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       run = 1'b0;
  logic       cmp_in = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       led_en;
  logic       latch_clr;
  logic       sample_valid;
  logic       sample_bit;
  logic [7:0] hit_count;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sense_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .run          (run),
    .cmp_in       (cmp_in),
    .cnt_clr      (cnt_clr),
    .led_en       (led_en),
    .latch_clr    (latch_clr),
    .sample_valid (sample_valid),
    .sample_bit   (sample_bit),
    .hit_count    (hit_count),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {led_en, latch_clr, sample_valid, sample_bit, busy};
  endfunction

  // expected {led_en, latch_clr, sample_valid, sample_bit, busy} in a running period
  function automatic logic [4:0] exp_vec(int tp, logic sb);
    logic le, lc, sv;
    le = (tp < 24);
    lc = (tp == 25) || (tp == 26);
    sv = (tp == 24);
    return {le, lc, sv, sb, 1'b1};
  endfunction

  task automatic do_reset();
    #2;
    rst = 1'b1;
    ena = 1'b0;
    run = 1'b0;
    cmp_in = 1'b0;
    cnt_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    run = 1'b1;
    cmp_in = 1'b1;
    tick();
    tick();
    vectors++;
    if (outs() !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_outs got %b want %b", outs(), 5'b00000);
    end
    vectors++;
    if (hit_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_hit got %0d want 0", hit_count);
    end
  endtask

  task automatic test_basic();
    logic [4:0] e;
    do_reset();
    ena = 1'b1;
    run = 1'b1;
    tick();
    for (int t = 0; t < 300; t++) begin
      e = exp_vec(t % 256, 1'b0);
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL basic t=%0d got %b want %b", t, outs(), e);
      end
      tick();
    end
    vectors++;
    if (hit_count !== 8'd0) begin
      miscompares++;
      $display("FAIL basic_hit got %0d want 0", hit_count);
    end
  endtask

  task automatic test_hits();
    do_reset();
    cmp_in = 1'b1;
    ena = 1'b1;
    run = 1'b1;
    tick();
    for (int t = 0; t < 768; t++) begin
      if (t % 256 == 24) begin
        vectors++;
        if ({sample_valid, sample_bit} !== 2'b11) begin
          miscompares++;
          $display("FAIL hits_sample t=%0d got %b want 11",
                   t, {sample_valid, sample_bit});
        end
      end
      tick();
    end
    vectors++;
    if (hit_count !== 8'd3) begin
      miscompares++;
      $display("FAIL hits_count got %0d want 3", hit_count);
    end
  endtask

  task automatic test_debounce();
    logic [1:0] e;
    do_reset();
    ena = 1'b1;
    run = 1'b1;
    tick();
    for (int t = 0; t <= 540; t++) begin
      if (t == 19) cmp_in = 1'b1;
      if (t == 530) cmp_in = 1'b0;
      if (t == 24 || t == 280 || t == 300 || t == 536) begin
        e = (t == 280) ? 2'b11 : (t == 300) ? 2'b01 : 2'b10;
        vectors++;
        if ({sample_valid, sample_bit} !== e) begin
          miscompares++;
          $display("FAIL debounce t=%0d got %b want %b",
                   t, {sample_valid, sample_bit}, e);
        end
      end
      tick();
    end
    vectors++;
    if (hit_count !== 8'd1) begin
      miscompares++;
      $display("FAIL debounce_hit got %0d want 1", hit_count);
    end
  endtask

  task automatic test_glitch();
    logic [1:0] e;
    do_reset();
    ena = 1'b1;
    run = 1'b1;
    tick();
    for (int t = 0; t <= 282; t++) begin
      if (t == 17) cmp_in = 1'b1;
      if (t == 20) cmp_in = 1'b0;
      if (t == 273) cmp_in = 1'b1;
      if (t == 277) cmp_in = 1'b0;
      if (t == 24 || t == 280) begin
        e = (t == 24) ? 2'b10 : 2'b11;
        vectors++;
        if ({sample_valid, sample_bit} !== e) begin
          miscompares++;
          $display("FAIL glitch t=%0d got %b want %b",
                   t, {sample_valid, sample_bit}, e);
        end
      end
      if (t == 26 || t == 282) begin
        vectors++;
        if (hit_count !== ((t == 26) ? 8'd0 : 8'd1)) begin
          miscompares++;
          $display("FAIL glitch_hit t=%0d got %0d", t, hit_count);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    logic [7:0] e;
    do_reset();
    cmp_in = 1'b1;
    ena = 1'b1;
    run = 1'b1;
    tick();
    for (int t = 0; t <= 261 * 256 + 25; t++) begin
      if (t == 260 * 256 + 24) begin
        cnt_clr = 1'b1;
        vectors++;
        if (sample_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL sat_clr_strobe got %b want 1", sample_valid);
        end
      end
      if (t == 260 * 256 + 25) cnt_clr = 1'b0;
      if (t == 254 * 256 + 24 || t == 254 * 256 + 25 ||
          t == 259 * 256 + 30 || t == 260 * 256 + 25 ||
          t == 261 * 256 + 25) begin
        e = (t == 254 * 256 + 24) ? 8'd254 :
            (t == 260 * 256 + 25) ? 8'd0 :
            (t == 261 * 256 + 25) ? 8'd1 : 8'd255;
        vectors++;
        if (hit_count !== e) begin
          miscompares++;
          $display("FAIL sat_hit t=%0d got %0d want %0d", t, hit_count, e);
        end
      end
      tick();
    end
  endtask

  task automatic test_run_drop();
    logic [4:0] e;
    do_reset();
    ena = 1'b1;
    run = 1'b1;
    tick();
    for (int t = 0; t <= 40; t++) begin
      e = (t < 27) ? exp_vec(t, 1'b0) : 5'b00000;
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL run_drop t=%0d got %b want %b", t, outs(), e);
      end
      if (t == 10) run = 1'b0;
      tick();
    end
  endtask

  task automatic test_ena_drop();
    logic [4:0] e;
    do_reset();
    cmp_in = 1'b1;
    ena = 1'b1;
    run = 1'b1;
    tick();
    for (int t = 0; t <= 300; t++) begin
      if (t >= 256) begin
        e = (t - 256 < 6) ? exp_vec(t - 256, 1'b1) : 5'b00010;
        vectors++;
        if (outs() !== e) begin
          miscompares++;
          $display("FAIL ena_drop t=%0d got %b want %b", t, outs(), e);
        end
      end
      if (t == 256 + 5) ena = 1'b0;
      tick();
    end
    vectors++;
    if (hit_count !== 8'd1) begin
      miscompares++;
      $display("FAIL ena_drop_hit got %0d want 1", hit_count);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    cmp_in = 1'b1;
    ena = 1'b1;
    run = 1'b1;
    tick();
    for (int t = 0; t < 256 + 20; t++) tick();
    vectors++;
    if ({led_en, busy, hit_count} !== {2'b11, 8'd1}) begin
      miscompares++;
      $display("FAIL rst_mid_pre got %b %b %0d want 1 1 1",
               led_en, busy, hit_count);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (outs() !== 5'b00000) begin
      miscompares++;
      $display("FAIL rst_mid_outs got %b want 00000", outs());
    end
    vectors++;
    if (hit_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_mid_hit got %0d want 0", hit_count);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hits();
    test_debounce();
    test_glitch();
    test_saturation();
    test_run_drop();
    test_ena_drop();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
